// File: rtl/pulse_link_pkg.sv
// Shared definitions for the single-wire pulse-count select link.
// Both the transmitter and receiver pull their timing defaults from here.
package pulse_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } pulse_state_e;

    localparam int DEF_SEL_W    = 3;
    localparam int DEF_HIGH_CYC = 2;
    localparam int DEF_LOW_CYC  = 2;
    localparam int DEF_GAP_CYC  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Wide enough to hold the longest phase length without wrapping.
    function automatic int phase_cnt_w(input int h, input int l, input int g);
        return $clog2(max3(h, l, g)) + 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter: load captures value-1, expire is high while the count sits at 0.
// The count holds at 0 rather than wrapping.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value - ONE;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - ONE;
        end
    end

    assign expire = (count_reg == '0);

endmodule

// File: rtl/pulse_train_tx.sv
// Pulse-count transmitter: sends code+1 fixed-width pulses on a_out, then a low gap
// long enough for the receiver to treat it as a frame delimiter.
module pulse_train_tx
    import pulse_link_pkg::*;
#(
    parameter int SEL_W    = DEF_SEL_W,
    parameter int HIGH_CYC = DEF_HIGH_CYC,
    parameter int LOW_CYC  = DEF_LOW_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic             a_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = phase_cnt_w(HIGH_CYC, LOW_CYC, GAP_CYC);

    localparam logic [CNT_W-1:0] HIGH_VAL = CNT_W'(HIGH_CYC);
    localparam logic [CNT_W-1:0] LOW_VAL  = CNT_W'(LOW_CYC);
    localparam logic [CNT_W-1:0] GAP_VAL  = CNT_W'(GAP_CYC);
    localparam logic [SEL_W:0]   REM_ONE  = (SEL_W+1)'(1);

    pulse_state_e     state_reg, state_next;
    logic [SEL_W:0]   remaining_reg, remaining_next;
    logic             ready_reg;
    logic             a_out_reg;
    logic             done_reg;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expire;
    logic             handshake;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    // ready_reg keeps sel_ready low until the first clock after reset is released.
    assign sel_ready = ready_reg && (state_reg == ST_IDLE);
    assign handshake = sel_valid && sel_ready;

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        tmr_load       = 1'b0;
        tmr_value      = HIGH_VAL;
        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    remaining_next = {1'b0, sel_in} + REM_ONE;
                    state_next     = ST_HIGH;
                    tmr_load       = 1'b1;
                    tmr_value      = HIGH_VAL;
                end
            end
            ST_HIGH: begin
                if (tmr_expire) begin
                    state_next = ST_LOW;
                    tmr_load   = 1'b1;
                    tmr_value  = LOW_VAL;
                end
            end
            ST_LOW: begin
                if (tmr_expire) begin
                    remaining_next = remaining_reg - REM_ONE;
                    tmr_load       = 1'b1;
                    if (remaining_reg == REM_ONE) begin
                        state_next = ST_GAP;
                        tmr_value  = GAP_VAL;
                    end else begin
                        state_next = ST_HIGH;
                        tmr_value  = HIGH_VAL;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            ready_reg     <= 1'b0;
            a_out_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            ready_reg     <= 1'b1;
            // Registered from the next state so a_out is high exactly while in HIGH.
            a_out_reg     <= (state_next == ST_HIGH);
            done_reg      <= (state_reg == ST_GAP) && tmr_expire;
        end
    end

    assign a_out = a_out_reg;
    assign done  = done_reg;
    assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pulse_train_tx.sv
// Randomised scoreboard bench for pulse_train_tx: a cycle-indexed line model plus an
// independent pulse-counting decoder check every frame.
module tb_pulse_train_tx;

    localparam int SEL_W = 3;
    localparam int HIGH  = 2;
    localparam int LOW   = 2;
    localparam int GAP   = 8;
    localparam int P     = HIGH + LOW;

    typedef struct {
        int code;
        int h;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [SEL_W-1:0] sel_in = '0;
    logic             sel_valid = 1'b0;
    logic             sel_ready;
    logic             a_out;
    logic             busy;
    logic             done;

    int     cyc = 0;
    logic   rst_q = 1'b0;
    int     compared = 0;
    int     mismatched = 0;

    frame_t exp_q[$];
    int     dec_q[$];
    frame_t cur;
    bit     active = 1'b0;

    int     pulses = 0;
    int     low_run = 0;
    logic   prev_a = 1'b0;

    pulse_train_tx #(
        .SEL_W    (SEL_W),
        .HIGH_CYC (HIGH),
        .LOW_CYC  (LOW),
        .GAP_CYC  (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_in    (sel_in),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .a_out     (a_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    function automatic void chk(input string name, input logic act, input logic expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, expv);
        end
    endfunction

    // Line model: cycle k after a handshake for code s. Pulse n occupies
    // k in [(n*P)+1, (n*P)+HIGH]; the burst spans (s+1)*P cycles, then GAP low
    // cycles, then done on the first idle cycle.
    always @(negedge clk) begin
        if (cyc != 0) begin
            logic ea, eb, er, ed;
            int   k, f, burst;
            ea = 1'b0; eb = 1'b0; er = 1'b1; ed = 1'b0;
            if (!rst_q) begin
                er     = 1'b0;
                active = 1'b0;
                exp_q.delete();
            end else if (active) begin
                k     = cyc - cur.h;
                burst = (cur.code + 1) * P;
                f     = burst + GAP;
                if (k >= 1 && k <= f) begin
                    eb = 1'b1;
                    er = 1'b0;
                    ea = (k <= burst) && (((k - 1) % P) < HIGH);
                end else if (k == f + 1) begin
                    ed     = 1'b1;
                    active = 1'b0;
                end
            end
            chk("a_out", a_out, ea);
            chk("busy", busy, eb);
            chk("sel_ready", sel_ready, er);
            chk("done", done, ed);
            if (rst_q && !active && exp_q.size() > 0) begin
                cur    = exp_q.pop_front();
                active = 1'b1;
            end
        end
    end

    // Receiver-style decoder: count rising edges, close the frame after GAP low cycles.
    always @(negedge clk) begin
        if (cyc != 0) begin
            if (!rst_q) begin
                pulses  = 0;
                low_run = 0;
                prev_a  = 1'b0;
                dec_q.delete();
            end else begin
                if (a_out === 1'b1) begin
                    if (prev_a !== 1'b1) pulses++;
                    low_run = 0;
                end else begin
                    low_run++;
                    if (low_run == GAP && pulses > 0) begin
                        compared++;
                        if (dec_q.size() == 0) begin
                            mismatched++;
                            $display("FAIL decode cyc=%0d got=%0d pulses expected=no frame", cyc, pulses);
                        end else begin
                            int code;
                            code = dec_q.pop_front();
                            $display("frame decoded: %0d pulses, code %0d at cyc=%0d", pulses, code, cyc);
                            if (pulses - 1 != code) begin
                                mismatched++;
                                $display("FAIL decode cyc=%0d got=%0d expected=%0d", cyc, pulses - 1, code);
                            end
                        end
                        pulses = 0;
                    end
                end
                prev_a = a_out;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input int code, input bit keep);
        int     n;
        frame_t fr;
        n         = 0;
        sel_in    = SEL_W'(code);
        sel_valid = 1'b1;
        while (!sel_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sel_ready) begin
            compared++;
            mismatched++;
            $display("FAIL handshake_timeout code=%0d got=no ready expected=ready", code);
            sel_valid = 1'b0;
            return;
        end
        fr.code = code;
        fr.h    = cyc;
        exp_q.push_back(fr);
        dec_q.push_back(code);
        $display("send code=%0d handshake at cyc=%0d", code, cyc);
        @(negedge clk);
        if (!keep) sel_valid = 1'b0;
    endtask

    // Wiggle the inputs while the frame runs, going quiet on the first ready cycle.
    task automatic busy_noise();
        for (int i = 0; i < 200; i++) begin
            if (sel_ready) begin
                sel_valid = 1'b0;
                return;
            end
            sel_valid = 1'($urandom);
            sel_in    = SEL_W'($urandom);
            @(negedge clk);
        end
        sel_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(0, 1'b0);
        send(7, 1'b0);
        for (int c = 0; c < 8; c++) begin
            send(c, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        send(3, 1'b1);
        send(5, 1'b0);

        send(2, 1'b0);
        sel_in = 3'd6;
        busy_noise();

        send(4, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            bit keep;
            keep = (i != 15) && ($urandom_range(0, 1) == 1);
            send($urandom_range(0, 7), keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        sel_valid = 1'b0;

        repeat (60) @(negedge clk);
        compared++;
        if (exp_q.size() != 0 || active) begin
            mismatched++;
            $display("FAIL drain_line got=%0d pending expected=0", exp_q.size() + int'(active));
        end
        compared++;
        if (dec_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_decode got=%0d pending expected=0", dec_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
